alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised multi-cycle successor of the datapath's combinational ALU.
- Keeps the same 4-bit operation encoding and zero flag, generalised to WIDTH bits.
- Single-cycle logic/add ops complete in one cycle; MUL/DIV/MOD run iteratively (shift-add / restoring) to remove the wide combinational multiplier/divider.
- Valid/ready handshake on both sides; sits between register-file read stage and writeback in the multi-cycle datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept (high only in IDLE)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sel  in  4  operation select
- out_valid  out  1  result valid, held until taken
- out_ready  in  1  consumer takes result
- res  out  WIDTH  result
- zf  out  1  res == 0
- dz  out  1  divide/modulo by zero occurred (DIV/MOD only)

Behaviour:
- Reset (rst=1 at clk edge): state IDLE, in_ready=1, out_valid=0, res=0, zf=1, dz=0, counter=0; any op in flight is discarded, no out_valid follows.
- Accept on an edge with in_valid && in_ready: a, b, sel latched; inputs ignored thereafter until next IDLE.
- States: IDLE -> DONE (single-cycle ops, or DIV/MOD with b==0); IDLE -> CALC (MUL, DIV, MOD with b!=0); CALC -> DONE when counter reaches WIDTH; DONE -> IDLE on edge with out_ready=1.
- Ops (all unsigned unless stated):
- 0000 AND, 0001 OR, 0010 ADD mod 2^WIDTH, 0100 NOR, 0110 SUB mod 2^WIDTH, 0111 XOR.
- 1001 SLTU: res = {0..., a<b}. 1011 SLTS: signed a<b, same format. 1101 SGTZ: signed a>0.
- 1100 NOT b. 1110 all ones. 1111 zero.
- 0101 MUL: low WIDTH bits of a*b.
- 1000 DIV: quotient. 0011 MOD: remainder.
- 1010 (unused): res=0, treated as single-cycle.
- Latency: single-cycle op accepted at edge k -> out_valid high from edge k+1. Iterative op -> CALC performs exactly one bit per edge, out_valid high from edge k+WIDTH+1.
- Divide by zero: DIV res = all ones, MOD res = a, dz=1, single-cycle latency. dz=0 for every other result.
- res, zf, dz update only when entering DONE; stable while out_valid=1 and out_ready=0. Not gated to zero afterwards.
- zf = (res == 0) computed on final WIDTH-bit result.
- in_ready=0 during CALC and DONE; no overlap. Next accept is possible the edge after the DONE->IDLE handshake edge (one bubble).
- out_ready while out_valid=0 has no effect.

Optional Feature:
- ALU_OVF_EN: adds output port ovf (1 bit).
- With the macro: ovf=1 when the result of ADD/SUB overflows as signed two's complement, else 0. ovf is updated with res and reset to 0.
- Without the macro: port absent, no overflow logic.

Test Plan:
- Reset mid-MUL: accept 0x0000_0007*0x0000_0009, assert rst at cycle 5 -> out_valid never rises, in_ready=1, res=0, zf=1 next cycle.
- ADD 0xFFFF_FFFF+1 accepted at edge k -> out_valid at k+1, res=0, zf=1. With ALU_OVF_EN, ovf=0. With 0x7FFF_FFFF+1: ovf=1.
- MUL 0x0001_0000*0x0001_0000 -> out_valid exactly at k+33, res=0, zf=1. MUL 123*456 -> res=56088.
- DIV 100/7 -> res=14. MOD 100%7 -> res=2, both at k+33 with dz=0. DIV 5/0 -> res=0xFFFF_FFFF, dz=1 at k+1. MOD 5/0 -> res=5, dz=1.
- Backpressure: hold out_ready=0 for 10 cycles after SUB 3-5 -> res=0xFFFF_FFFE stable, in_ready=0. New in_valid is ignored until one cycle after out_ready=1.
- SLTS a=0xFFFF_FFFF, b=1 -> res=1. SLTU with the same operands -> res=0, zf=1. WIDTH=8 rerun: MUL 16*16 -> res=0 at k+9.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add MUL and restoring DIV/MOD.
// Define ALU_OVF_EN to add the signed-overflow output ovf for ADD/SUB.
module alu_seq #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zf,
`ifdef ALU_OVF_EN
  output logic             ovf,
`endif
  output logic             dz
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000, OP_OR   = 4'b0001, OP_ADD  = 4'b0010, OP_MOD  = 4'b0011,
    OP_NOR  = 4'b0100, OP_MUL  = 4'b0101, OP_SUB  = 4'b0110, OP_XOR  = 4'b0111,
    OP_DIV  = 4'b1000, OP_SLTU = 4'b1001, OP_RSVD = 4'b1010, OP_SLTS = 4'b1011,
    OP_NOT  = 4'b1100, OP_SGTZ = 4'b1101, OP_ONES = 4'b1110, OP_ZERO = 4'b1111
  } op_e;

  state_e           state;
  op_e              op_q;
  logic [CNT_W-1:0] cnt;
  // MUL: acc = product, sh_a = shifted multiplicand, sh_b = shifted multiplier.
  // DIV/MOD: acc = partial remainder, sh_a = dividend shifting into quotient, sh_b = divisor.
  logic [WIDTH-1:0] acc, sh_a, sh_b;

  op_e              op_in;
  logic [WIDTH-1:0] sum, diff, fast_res;
  logic             iter_op, div_zero;

  assign op_in    = op_e'(sel);
  assign sum      = a + b;
  assign diff     = a - b;
  assign iter_op  = (op_in == OP_MUL) || (op_in == OP_DIV) || (op_in == OP_MOD);
  assign div_zero = ((op_in == OP_DIV) || (op_in == OP_MOD)) && (b == '0);

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    fast_res = '0;
    case (op_in)
      OP_AND:  fast_res = a & b;
      OP_OR:   fast_res = a | b;
      OP_ADD:  fast_res = sum;
      OP_NOR:  fast_res = ~(a | b);
      OP_SUB:  fast_res = diff;
      OP_XOR:  fast_res = a ^ b;
      OP_SLTU: fast_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLTS: fast_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SGTZ: fast_res = {{(WIDTH-1){1'b0}}, (!a[WIDTH-1] && (a != '0))};
      OP_NOT:  fast_res = ~b;
      OP_ONES: fast_res = '1;
      OP_DIV:  fast_res = '1;   // only reached for a zero divisor
      OP_MOD:  fast_res = a;    // only reached for a zero divisor
      default: fast_res = '0;
    endcase
  end

`ifdef ALU_OVF_EN
  logic fast_ovf;
  always_comb begin
    fast_ovf = 1'b0;
    if (op_in == OP_ADD)
      fast_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    else if (op_in == OP_SUB)
      fast_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  end
`endif

  // One iteration of shift-add multiply or restoring division.
  logic [WIDTH-1:0] acc_nxt, sh_a_nxt, sh_b_nxt, iter_res;
  logic [WIDTH:0]   rem_sh, rem_sub;

  always_comb begin
    acc_nxt  = acc;
    sh_a_nxt = sh_a;
    sh_b_nxt = sh_b;
    rem_sh   = {acc, sh_a[WIDTH-1]};
    rem_sub  = rem_sh - {1'b0, sh_b};
    if (op_q == OP_MUL) begin
      if (sh_b[0]) acc_nxt = acc + sh_a;
      sh_a_nxt = sh_a << 1;
      sh_b_nxt = sh_b >> 1;
    end else if (!rem_sub[WIDTH]) begin
      acc_nxt  = rem_sub[WIDTH-1:0];
      sh_a_nxt = {sh_a[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt  = rem_sh[WIDTH-1:0];
      sh_a_nxt = {sh_a[WIDTH-2:0], 1'b0};
    end
  end

  assign iter_res  = (op_q == OP_DIV) ? sh_a_nxt : acc_nxt;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too, so res/zf/dz are defined straight out of reset.
      state <= IDLE;
      op_q  <= OP_ZERO;
      cnt   <= '0;
      acc   <= '0;
      sh_a  <= '0;
      sh_b  <= '0;
      res   <= '0;
      zf    <= 1'b1;
      dz    <= 1'b0;
`ifdef ALU_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_q <= op_in;
          cnt  <= '0;
          if (iter_op && !div_zero) begin
            state <= CALC;
            acc   <= '0;
            sh_a  <= a;
            sh_b  <= b;
          end else begin
            state <= DONE;
            res   <= fast_res;
            zf    <= (fast_res == '0);
            dz    <= div_zero;
`ifdef ALU_OVF_EN
            ovf   <= fast_ovf;
`endif
          end
        end
        CALC: begin
          acc  <= acc_nxt;
          sh_a <= sh_a_nxt;
          sh_b <= sh_b_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= DONE;
            res   <= iter_res;
            zf    <= (iter_res == '0);
            dz    <= 1'b0;
`ifdef ALU_OVF_EN
            ovf   <= 1'b0;
`endif
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
